// File: rtl/ecc_pkg.sv
// Shared constants for the GF(2^233) arithmetic sequencer: widths, instruction
// field positions, FSM state encoding and the R2 start-time value.
package ecc_pkg;

  localparam int unsigned WIDTH   = 233;
  localparam int unsigned CW_W    = 10;
  localparam int unsigned INSTR_W = 17;

  localparam int unsigned C0_DST_LSB = 10;
  localparam int unsigned C0_WE_BIT  = 12;
  localparam int unsigned C1_DST_LSB = 13;
  localparam int unsigned C1_WE_BIT  = 15;
  localparam int unsigned LAST_BIT   = 16;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StExec  = 3'd2;
  localparam logic [2:0] StWb    = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  // Projective Z coordinate starts at 1.
  localparam logic [WIDTH-1:0] R2_INIT = WIDTH'(1);

endpackage

// File: rtl/ecc_regfile4.sv
// Four WIDTH-bit field registers with two write ports (port 1 wins on a
// shared destination) and a load port for start-time initialisation.
module ecc_regfile4
  import ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             we0_i,
  input  logic [1:0]       dst0_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic             we1_i,
  input  logic [1:0]       dst1_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] r0_o,
  output logic [WIDTH-1:0] r1_o,
  output logic [WIDTH-1:0] r2_o,
  output logic [WIDTH-1:0] r3_o
);

  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    if (load_i) begin
      regs_d[0] = x_i;
      regs_d[1] = y_i;
      regs_d[2] = R2_INIT;
      regs_d[3] = '0;
    end else begin
      // Port 1 is applied last so it wins when both target the same register.
      if (we0_i) regs_d[dst0_i] = d0_i;
      if (we1_i) regs_d[dst1_i] = d1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign r0_o = regs_q[0];
  assign r1_o = regs_q[1];
  assign r2_o = regs_q[2];
  assign r3_o = regs_q[3];

endmodule

// File: rtl/ecc_arith_sequencer.sv
// Microcoded sequencer around the GF(2^233) arithmetic unit: fetches from an
// external ROM, holds cword/operands for EXEC_CYC cycles, then writes back c0/c1.
module ecc_arith_sequencer
  import ecc_pkg::*;
#(
  parameter int unsigned EXEC_CYC = 4,
  parameter int unsigned PC_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [WIDTH-1:0]   a0,
  output logic [WIDTH-1:0]   a1,
  output logic [WIDTH-1:0]   a2,
  output logic [WIDTH-1:0]   a3,
  output logic [CW_W-1:0]    cword,
  input  logic [WIDTH-1:0]   c0,
  input  logic [WIDTH-1:0]   c1,
  output logic               busy,
  output logic               done
);

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               load;
  logic               wb;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    wb      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        ir_d    = instr_in;
        cnt_d   = '0;
        state_d = StExec;
      end
      StExec: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(EXEC_CYC - 1)) state_d = StWb;
      end
      StWb: begin
        wb = 1'b1;
        if (ir_q[LAST_BIT]) begin
          state_d = StDone;
        end else begin
          // A missing last bit lets pc wrap silently.
          pc_d    = pc_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  ecc_regfile4 u_regfile (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .x_i    (x_in),
    .y_i    (y_in),
    .we0_i  (wb & ir_q[C0_WE_BIT]),
    .dst0_i (ir_q[C0_DST_LSB +: 2]),
    .d0_i   (c0),
    .we1_i  (wb & ir_q[C1_WE_BIT]),
    .dst1_i (ir_q[C1_DST_LSB +: 2]),
    .d1_i   (c1),
    .r0_o   (a0),
    .r1_o   (a1),
    .r2_o   (a2),
    .r3_o   (a3)
  );

  // cword is the registered IR field, so it only moves on FETCH->EXEC.
  assign cword      = ir_q[CW_W-1:0];
  assign instr_addr = pc_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_ecc_arith_sequencer.sv
// Self-checking bench: ROM and arithmetic-unit stub live here; each program's
// register results and timing are predicted from the instruction semantics.
module tb_ecc_arith_sequencer;

  localparam int W   = 233;
  localparam int EC  = 4;
  localparam int PER = EC + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  x_in, y_in;
  logic [5:0]    instr_addr;
  logic [16:0]   instr_in;
  logic [W-1:0]  a0, a1, a2, a3;
  logic [9:0]    cword;
  logic [W-1:0]  c0, c1;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  logic [16:0]  rom  [64];
  logic [16:0]  prog [64];
  bit           use_ovr;
  logic [W-1:0] c0_ovr, c1_ovr;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] stub0(input logic [W-1:0] p, input logic [W-1:0] q,
                                         input logic [9:0] cw);
    return p ^ {q[W-2:0], q[W-1]} ^ W'(cw);
  endfunction

  function automatic logic [W-1:0] stub1(input logic [W-1:0] r, input logic [W-1:0] s,
                                         input logic [9:0] cw);
    return r + s + W'(cw);
  endfunction

  assign instr_in = rom[instr_addr];
  assign c0 = use_ovr ? c0_ovr : stub0(a0, a1, cword);
  assign c1 = use_ovr ? c1_ovr : stub1(a2, a3, cword);

  ecc_arith_sequencer #(.EXEC_CYC(EC), .PC_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .instr_addr (instr_addr),
    .instr_in   (instr_in),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .cword      (cword),
    .c0         (c0),
    .c1         (c1),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic logic [16:0] mk(input bit last, input bit we1, input logic [1:0] d1,
                                     input bit we0, input logic [1:0] d0,
                                     input logic [9:0] cw);
    return {last, we1, d1, we0, d0, cw};
  endfunction

  // Run prog[0..n-1] from the current negedge; optionally poke start while busy
  // and in the DONE cycle (both must be ignored).
  task automatic run_prog(input int n, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke);
    logic [W-1:0] m [4];
    logic [W-1:0] v0, v1;
    logic [9:0]   cw;
    int           last_j, k, ph;
    m[0] = x; m[1] = y; m[2] = W'(1); m[3] = '0;
    for (int i = 0; i < n; i++) begin
      cw = prog[i][9:0];
      v0 = use_ovr ? c0_ovr : stub0(m[0], m[1], cw);
      v1 = use_ovr ? c1_ovr : stub1(m[2], m[3], cw);
      if (prog[i][12]) m[prog[i][11:10]] = v0;
      if (prog[i][15]) m[prog[i][14:13]] = v1;
    end
    for (int i = 0; i < n; i++) rom[i] = prog[i];
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    last_j = 1 + PER * n;
    for (int j = 1; j <= last_j + 1; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && (j == 3 || j == last_j)) begin
        start = 1'b1;
        x_in  = ~x;
        y_in  = ~y;
      end
      check(j <= last_j ? "busy" : "busy_after", W'(busy), W'(j <= last_j));
      check("done", W'(done), W'(j == last_j));
      if (j < last_j) begin
        k  = (j - 1) / PER;
        ph = (j - 1) % PER;
        if (ph == 0) begin
          check("instr_addr", W'(instr_addr), W'(k));
        end else if (ph <= EC) begin
          check("cword_exec", W'(cword), W'(prog[k][9:0]));
          if (ph == 2) rom[k] = 17'($urandom);
        end
      end
    end
    start = 1'b0;
    check("r0", a0, m[0]);
    check("r1", a1, m[1]);
    check("r2", a2, m[2]);
    check("r3", a3, m[3]);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) rom[i] = '0;
    use_ovr = 1'b0;
    c0_ovr  = '0;
    c1_ovr  = '0;
    rst     = 1'b1;
    start   = 1'b0;
    x_in    = '0;
    y_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_a0", a0, '0);
    check("rst_a3", a3, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_cword", W'(cword), '0);
    check("rst_addr", W'(instr_addr), '0);
    rst = 1'b0;

    // Reset in the middle of EXEC aborts without writeback.
    rom[0] = mk(1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 10'h155);
    x_in  = W'(5);
    y_in  = W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_a0", a0, W'(5));
    check("mid_cword", W'(cword), W'(10'h155));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_a0", a0, '0);
    check("abort_a1", a1, '0);
    check("abort_a2", a2, '0);
    check("abort_a3", a3, '0);
    check("abort_busy", W'(busy), '0);
    check("abort_cword", W'(cword), '0);
    repeat (EC + 3) @(negedge clk);
    check("abort_stay_idle", W'(busy), '0);
    check("abort_no_wb", a0, '0);

    // Single instruction writing a fixed c0 into R3.
    use_ovr = 1'b1;
    c0_ovr  = W'(12'hABC);
    c1_ovr  = W'(12'h777);
    prog[0] = mk(1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 10'h000);
    run_prog(1, rnd(), rnd(), 1'b0);

    // Dual write to R2: c1 wins. Starts poked while busy and in DONE.
    c0_ovr  = W'(8'h11);
    c1_ovr  = W'(8'h22);
    prog[0] = mk(1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 10'h3A5);
    run_prog(1, rnd(), rnd(), 1'b1);

    // No-op with last, started one cycle after done: registers back to init.
    prog[0] = mk(1'b1, 1'b0, 2'd1, 1'b0, 2'd2, 10'h0F0);
    run_prog(1, rnd(), rnd(), 1'b0);
    check("cword_hold", W'(cword), W'(10'h0F0));
    use_ovr = 1'b0;

    // Three-instruction program using the operand-dependent stub.
    prog[0] = mk(1'b0, 1'b1, 2'd2, 1'b1, 2'd3, 10'(($urandom)));
    prog[1] = mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 10'(($urandom)));
    prog[2] = mk(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 10'(($urandom)));
    run_prog(3, rnd(), rnd(), 1'b1);

    // Random programs.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++)
        prog[k] = mk(k == n - 1, 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                     10'($urandom));
      run_prog(n, rnd(), rnd(), 1'($urandom));
      check("cword_hold_rand", W'(cword), W'(prog[n-1][9:0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
